// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_e;

    // Opcodes shared with the decoder and sign_extend
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational ID/EX load-use hazard comparator
//
// Ports:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2 : ID instruction sources
//   ex_valid, ex_mem_read, ex_rd                     : EX instruction destination
//   hazard                                           : ID needs a load result not yet available
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;
    logic ex_is_load;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign ex_is_load = ex_valid && ex_mem_read && (ex_rd != '0);
    assign rs1_match  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match  = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard     = ex_is_load && id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   id_* / ex_*                         : hazard and branch sources from ID and EX
//   mem_req, mem_ack                    : MEM stage data access handshake
//   pc_en .. mem_wb_en                  : stage register load enables
//   if_id_flush, id_ex_flush            : bubble loads into IF/ID, ID/EX
//   mem_wb_bubble                       : MEM/WB captures a bubble
//   pc_sel_branch                       : PC mux takes the branch target
//   mem_timeout_err                     : sticky memory-timeout flag
//   stall_cnt                           : saturating count of cycles with pc_en=0
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch,
    input  logic                  ex_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  pc_sel_branch,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic mem_stall;
    logic branch_taken;
    logic load_use;
    logic timeout_hit;
    logic cnt_inc;

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (load_use)
    );

    assign mem_stall    = mem_req && !mem_ack;
    assign branch_taken = ex_valid && ex_branch && ex_taken;
    assign timeout_hit  = (state_q == MEM_WAIT) && mem_stall
                          && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (cnt_inc && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        pc_sel_branch = 1'b0;

        if (!rst_n) begin
            // Hold every stage and fill with bubbles while reset is asserted
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_q == ERR) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (mem_stall) begin
            // Freeze everything upstream of MEM; any branch or load-use
            // sitting in EX/ID is re-evaluated once the access completes
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            wait_d        = wait_q + WAIT_W'(1);
            state_d       = timeout_hit ? ERR : MEM_WAIT;
        end else begin
            // RUN, or MEM_WAIT on the ack/drop cycle, behaves as a RUN cycle
            state_d = RUN;
            wait_d  = '0;
            if (branch_taken) begin
                // The squashed ID instruction makes any load-use moot
                pc_sel_branch = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign cnt_inc         = rst_n && (state_q != ERR) && !pc_en;
    assign mem_timeout_err = err_q || timeout_hit;
    assign stall_cnt       = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard testbench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int RW      = 5;
    localparam int TIMEOUT = 16;
    localparam int CW      = 6;

    typedef struct packed {
        logic          rst_n;
        logic          id_valid;
        logic [RW-1:0] id_rs1;
        logic [RW-1:0] id_rs2;
        logic          id_use_rs1;
        logic          id_use_rs2;
        logic          ex_valid;
        logic          ex_mem_read;
        logic [RW-1:0] ex_rd;
        logic          ex_branch;
        logic          ex_taken;
        logic          mem_req;
        logic          mem_ack;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [8:0]  ctl;
        logic        err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          id_valid, id_use_rs1, id_use_rs2;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          ex_valid, ex_mem_read, ex_branch, ex_taken, mem_req, mem_ack;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, pc_sel_branch;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cnt;

    pipeline_ctrl #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch       (ex_branch),
        .ex_taken        (ex_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .pc_sel_branch   (pc_sel_branch),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;

    // Reference model state: consecutive un-acked request cycles, dead flag, stall total
    int   consec = 0;
    bit   dead   = 0;
    int   m_cnt  = 0;

    // ctl order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble, pc_sel
    task automatic apply(input stim_t s);
        exp_t e;
        bit   lu;
        bit   stall;
        @(negedge clk);
        rst_n       = s.rst_n;
        id_valid    = s.id_valid;
        id_rs1      = s.id_rs1;
        id_rs2      = s.id_rs2;
        id_use_rs1  = s.id_use_rs1;
        id_use_rs2  = s.id_use_rs2;
        ex_valid    = s.ex_valid;
        ex_mem_read = s.ex_mem_read;
        ex_rd       = s.ex_rd;
        ex_branch   = s.ex_branch;
        ex_taken    = s.ex_taken;
        mem_req     = s.mem_req;
        mem_ack     = s.mem_ack;
        cyc++;

        e.cyc = cyc;
        e.err = 1'b0;
        lu    = s.ex_valid && s.ex_mem_read && (s.ex_rd != 0) && s.id_valid
                && ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
        stall = s.mem_req && !s.mem_ack;

        if (!s.rst_n) begin
            consec = 0;
            dead   = 0;
            m_cnt  = 0;
            e.ctl  = 9'b00000_1110;
            e.cnt  = '0;
        end else if (dead) begin
            e.ctl = 9'b0;
            e.err = 1'b1;
            e.cnt = CW'(m_cnt);
        end else if (stall) begin
            e.ctl  = 9'b00001_0010;
            e.cnt  = CW'(m_cnt);
            consec = consec + 1;
            if (consec == TIMEOUT) begin
                e.err = 1'b1;
                dead  = 1;
            end
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
            consec = 0;
            e.cnt  = CW'(m_cnt);
            if (s.ex_valid && s.ex_branch && s.ex_taken) begin
                e.ctl = 9'b11111_1101;
            end else if (lu) begin
                e.ctl = 9'b00111_0100;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else begin
                e.ctl = 9'b11111_0000;
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Monitor: one output set per cycle, sampled well after the driving edge
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_bubble, pc_sel_branch};
                tests++;
                if (act !== e.ctl) begin
                    fails++;
                    $display("FAIL ctl cyc=%0d got=%b want=%b", e.cyc, act, e.ctl);
                end
                tests++;
                if (mem_timeout_err !== e.err) begin
                    fails++;
                    $display("FAIL timeout_err cyc=%0d got=%b want=%b", e.cyc, mem_timeout_err, e.err);
                end
                tests++;
                if (stall_cnt !== e.cnt) begin
                    fails++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        {id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_mem_read, ex_branch, ex_taken,
         mem_req, mem_ack} = '0;
        id_rs1 = '0;
        id_rs2 = '0;
        ex_rd  = '0;

        s = idle(); s.rst_n = 1'b0;
        apply(s); apply(s);
        apply(idle()); apply(idle());

        // LD x5 in EX, ADDI rs1=x5 in ID: one bubble, then normal
        s = idle();
        s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rd = 5;
        s.id_valid = 1; s.id_rs1 = 5; s.id_use_rs1 = 1;
        apply(s);
        apply(idle());

        // LD x0 against rs1=x0: no hazard
        s = idle();
        s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rd = 0;
        s.id_valid = 1; s.id_rs1 = 0; s.id_use_rs1 = 1;
        apply(s);

        // rs2 matches but is not read: no hazard
        s = idle();
        s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rd = 5;
        s.id_valid = 1; s.id_rs1 = 3; s.id_use_rs1 = 1; s.id_rs2 = 5; s.id_use_rs2 = 0;
        apply(s);

        // Taken branch with load-use also true: branch wins
        s = idle();
        s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rd = 5; s.ex_branch = 1; s.ex_taken = 1;
        s.id_valid = 1; s.id_rs2 = 5; s.id_use_rs2 = 1;
        apply(s);

        // Three wait cycles then ack
        s = idle(); s.mem_req = 1;
        apply(s); apply(s); apply(s);
        s.mem_ack = 1;
        apply(s);
        apply(idle());

        // Never acked: timeout, then ERR persists
        s = idle(); s.mem_req = 1;
        for (int i = 0; i < TIMEOUT + 3; i++) apply(s);
        apply(idle());
        s = idle(); s.ex_valid = 1; s.ex_branch = 1; s.ex_taken = 1;
        apply(s);

        // Reset clears ERR; then reset mid-wait
        s = idle(); s.rst_n = 1'b0;
        apply(s);
        apply(idle());
        s = idle(); s.mem_req = 1;
        apply(s); apply(s); apply(s);
        s.rst_n = 1'b0;
        apply(s);
        apply(idle()); apply(idle());

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            s.rst_n       = ($urandom_range(0, 299) != 0);
            s.id_valid    = ($urandom_range(0, 3) != 0);
            s.id_rs1      = RW'($urandom_range(0, 3));
            s.id_rs2      = RW'($urandom_range(0, 3));
            s.id_use_rs1  = $urandom_range(0, 1);
            s.id_use_rs2  = $urandom_range(0, 1);
            s.ex_valid    = ($urandom_range(0, 3) != 0);
            s.ex_mem_read = $urandom_range(0, 1);
            s.ex_rd       = RW'($urandom_range(0, 3));
            s.ex_branch   = ($urandom_range(0, 3) == 0);
            s.ex_taken    = $urandom_range(0, 1);
            s.mem_req     = ($urandom_range(0, 2) == 0) || (i >= 400 && i < 440);
            s.mem_ack     = (i >= 400 && i < 440) ? 1'b0 : ($urandom_range(0, 2) != 0);
            apply(s);
        end

        @(negedge clk);
        @(negedge clk);
        #4;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB). Each cycle it decides stage-register enables, bubbles and flushes from three sources: ID/EX load-use hazards, taken branches resolved in EX, and data-memory wait handshakes. It holds a small FSM for memory waits with a timeout. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1, id_rs2  in  REG_ADDR_W  source indices decoded in ID
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2 (LD/ADDI: rs1 only; SD/BEQ/BNE: both)
ex_valid  in  1  EX stage holds a real instruction
ex_mem_read  in  1  EX instruction is LD
ex_rd  in  REG_ADDR_W  EX destination index
ex_branch, ex_taken  in  1  EX is BEQ/BNE; branch outcome
mem_req, mem_ack  in  1  MEM stage data access request; memory completion
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register load enables
if_id_flush, id_ex_flush  out  1  load a bubble into IF/ID or ID/EX
mem_wb_bubble  out  1  MEM/WB loads a bubble instead of MEM results
pc_sel_branch  out  1  PC mux selects branch target
mem_timeout_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0 (saturating)

Behaviour:
- Reset (rst_n=0, async): state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout_err=0. While held: all *_en=0, if_id_flush=id_ex_flush=1, mem_wb_bubble=1, pc_sel_branch=0.
- FSM states: RUN, MEM_WAIT, ERR. Outputs combinational from state plus current inputs; zero-cycle latency.
- mem_stall = mem_req & ~mem_ack. Priority per cycle: mem_stall > branch > load-use > normal.
- Normal (RUN, no event): all enables 1, all flushes/bubbles 0, pc_sel_branch=0.
- mem_stall (RUN or MEM_WAIT): pc_en=if_id_en=id_ex_en=ex_mem_en=0. mem_wb_en=1 with mem_wb_bubble=1. No flushes. Any branch or load-use in EX/ID is frozen and re-evaluated after ack. RUN->MEM_WAIT, and wait_cnt increments.
- MEM_WAIT with mem_ack=1: treated as RUN for this cycle (normal/branch/load-use rules apply). ->RUN, wait_cnt=0. mem_req dropping without ack also returns to RUN.
- Timeout: mem_stall in MEM_WAIT with wait_cnt==MEM_TIMEOUT-1 -> ERR, mem_timeout_err=1. ERR is terminal until reset: all enables 0, bubbles/flushes 0.
- Branch taken (ex_valid&ex_branch&ex_taken, no mem_stall): pc_sel_branch=1, pc_en=1, if_id_flush=1, id_ex_flush=1. Other enables 1. Load-use is suppressed (ID instruction is squashed). Not-taken branch: normal.
- Load-use: ex_valid&ex_mem_read&(ex_rd!=0)&id_valid&((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd)). Response: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Exactly one bubble; the next cycle the load is in MEM and forwarding covers it.
- A flush takes effect only if the matching enable is 1; a flush overrides held data.
- stall_cnt: +1 on each cycle in RUN/MEM_WAIT with pc_en=0, saturating at all-ones. Frozen in ERR.

Decomposition:
- pipe_ctrl_pkg: ctrl_state_e enum {RUN, MEM_WAIT, ERR}, REG_ADDR_W default, opcode constants (OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_IMM 0010011) shared with the decoder/sign_extend.
- Sub-module load_use_detect (purely combinational comparator producing the hazard bit). FSM, counters and output muxing stay in pipeline_ctrl.

Test Plan:
- LD x5 in EX, ID ADDI rs1=x5 (use_rs1=1): 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal; stall_cnt=1.
- LD x0 in EX, ID rs1=x0: no stall. Also: ID SD rs2=x5 with use_rs2=0: no stall.
- Taken BEQ in EX while the load-use condition is also true: pc_sel_branch=1, if_id_flush=id_ex_flush=1, pc_en=1, no stall.
- mem_req=1, ack after 3 cycles: 3 cycles with all upstream enables 0 and mem_wb_bubble=1, state MEM_WAIT; ack cycle normal; stall_cnt=3.
- mem_req held, never acked, MEM_TIMEOUT=16: mem_timeout_err=1 on the 16th stall cycle. ERR persists with all enables 0 until rst_n low.
- rst_n asserted mid-MEM_WAIT: immediately state=RUN, stall_cnt=0, enables 0, flushes 1. After release with no events: all enables 1.
